// File: rtl/axi_ddr_pkg.sv
// Shared constants and types for the AXI-to-DDR burst path.
package axi_ddr_pkg;

    localparam int unsigned DEF_ADDRSIZE  = 34;
    localparam int unsigned DEF_IDWIDTH   = 3;
    localparam int unsigned DEF_DATAWIDTH = 128;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/axi_burst_splitter_if.sv
// Command-in / beat-out handshake bundle for the burst splitter.
interface axi_burst_splitter_if #(
    parameter int unsigned ADDRSIZE = 34,
    parameter int unsigned IDWIDTH  = 3
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IDWIDTH-1:0]  cmd_id;
    logic [ADDRSIZE-1:0] cmd_addr;
    logic [7:0]          cmd_len;
    logic [2:0]          cmd_size;
    logic [1:0]          cmd_burst;

    logic                beat_valid;
    logic                beat_ready;
    logic [IDWIDTH-1:0]  beat_id;
    logic [ADDRSIZE-1:0] beat_addr;
    logic [7:0]          beat_idx;
    logic                beat_last;
    logic                beat_err;

    // Splitter side: consumes commands, produces beats.
    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last, beat_err
    );

    // Environment side: produces commands, consumes beats.
    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last, beat_err
    );
endinterface

// File: rtl/axi_next_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_next_addr
    import axi_ddr_pkg::*;
#(
    parameter int unsigned ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic [ADDRSIZE-1:0] addr_i,
    input  logic [2:0]          size_i,
    input  logic [7:0]          len_i,
    input  logic [1:0]          burst_i,
    output logic [ADDRSIZE-1:0] next_addr_o
);
    logic [ADDRSIZE-1:0] step;
    logic [ADDRSIZE-1:0] wrap_bytes;
    logic [ADDRSIZE-1:0] wrap_base;
    logic [ADDRSIZE-1:0] inc_addr;

    // Address arithmetic is modulo 2^ADDRSIZE; INCR has no 4KB check.
    always_comb begin
        step        = ADDRSIZE'(1) << size_i;
        wrap_bytes  = (ADDRSIZE'(len_i) + ADDRSIZE'(1)) << size_i;
        wrap_base   = addr_i & ~(wrap_bytes - ADDRSIZE'(1));
        inc_addr    = addr_i + step;
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = (addr_i & ~(step - ADDRSIZE'(1))) + step;
            BURST_WRAP: next_addr_o = (inc_addr == wrap_base + wrap_bytes) ? wrap_base : inc_addr;
            default:    next_addr_o = addr_i;
        endcase
    end
endmodule

// File: rtl/axi_burst_splitter.sv
// Splits one AXI burst command into per-beat DDR address requests.
module axi_burst_splitter
    import axi_ddr_pkg::*;
#(
    parameter int unsigned ADDRSIZE  = DEF_ADDRSIZE,
    parameter int unsigned IDWIDTH   = DEF_IDWIDTH,
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH
) (
    input logic                 aclk,
    input logic                 rst,
    axi_burst_splitter_if.slave bus
);
    localparam int unsigned NB = DATAWIDTH / 8;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [IDWIDTH-1:0]  id_q, id_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [7:0]          idx_q, idx_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic                last_q, last_d;
    logic                err_q, err_d;

    logic                cmd_ready_c;
    logic                accept_c;
    logic                advance_c;
    logic                illegal_c;
    logic [ADDRSIZE-1:0] size_mask_c;
    logic [ADDRSIZE-1:0] next_addr_c;

    axi_next_addr #(.ADDRSIZE(ADDRSIZE)) u_next_addr (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr_c)
    );

    // Command legality check against the data-path width and AXI wrap rules.
    always_comb begin
        size_mask_c = (ADDRSIZE'(1) << bus.cmd_size) - ADDRSIZE'(1);
        illegal_c   = 1'b0;
        if ((32'(1) << bus.cmd_size) > 32'(NB))
            illegal_c = 1'b1;
        if (bus.cmd_burst == 2'b11)
            illegal_c = 1'b1;
        if (bus.cmd_burst == BURST_WRAP) begin
            if (!(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
                illegal_c = 1'b1;
            if ((bus.cmd_addr & size_mask_c) != '0)
                illegal_c = 1'b1;
        end
    end

    // Handshakes; the last-beat term lets a new command land with no bubble.
    always_comb begin
        advance_c   = valid_q && bus.beat_ready;
        cmd_ready_c = (state_q == IDLE) || (advance_c && last_q);
        accept_c    = bus.cmd_valid && cmd_ready_c;
    end

    // Next-state and next-beat computation.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        last_d  = last_q;
        err_d   = err_q;

        if (accept_c) begin
            state_d = BURST;
            valid_d = 1'b1;
            id_d    = bus.cmd_id;
            addr_d  = bus.cmd_addr;
            idx_d   = 8'd0;
            len_d   = bus.cmd_len;
            size_d  = bus.cmd_size;
            burst_d = bus.cmd_burst;
            last_d  = (bus.cmd_len == 8'd0);
            err_d   = illegal_c;
        end else if (state_q == BURST && advance_c) begin
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                idx_d  = idx_q + 8'd1;
                addr_d = err_q ? addr_q : next_addr_c;
                last_d = ((idx_q + 8'd1) == len_q);
            end
        end
    end

    // State and beat registers; reset abandons any burst in flight.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.beat_valid = valid_q;
    assign bus.beat_id    = id_q;
    assign bus.beat_addr  = addr_q;
    assign bus.beat_idx   = idx_q;
    assign bus.beat_last  = last_q;
    assign bus.beat_err   = err_q;
endmodule
